// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush controller for the 5-stage RISC-V pipeline. It drives
//   the enable/clear pair of every pipeline register and the PC enable. It
//   resolves three conditions in the current cycle:
//     - data-memory waits: freeze IF..MEM and bubble WB
//     - taken branches: flush IF/ID and ID/EX
//     - load-use hazards: hold PC and IF/ID, bubble ID/EX
//   It also keeps saturating stall/flush counters and a sticky memory-timeout
//   flag.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   id_rs1/id_rs2       source registers of the ID instruction
//   id_uses_rs1/rs2     ID instruction actually reads that source
//   ex_rd               destination register of the EX instruction
//   ex_mem_read         EX instruction is a load
//   ex_reg_write        EX instruction writes the register file
//   ex_branch_taken     branch/jump resolved taken in EX
//   mem_req/mem_ready   MEM stage access active / completes this cycle
//   pc_en               PC update enable
//   *_en / *_clr        enable/clear of IF/ID, ID/EX, EX/MEM, MEM/WB
//   stall_count         saturating count of cycles with pc_en=0
//   flush_count         saturating count of branch-flush cycles
//   mem_timeout         sticky flag, memory wait exceeded MEM_TIMEOUT cycles
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_reg_write,
    input  logic                  ex_branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  ifid_clr,
    output logic                  idex_en,
    output logic                  idex_clr,
    output logic                  exmem_en,
    output logic                  exmem_clr,
    output logic                  memwb_en,
    output logic                  memwb_clr,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count,
    output logic                  mem_timeout
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              frozen;
    logic              load_use;
    logic              flush_now;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v)
            return v;
        else
            return v + CNT_W'(1);
    endfunction

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    assign load_use = ex_mem_read && ex_reg_write && (ex_rd != '0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    // Once in MEM_WAIT the access is already in flight, so only mem_ready
    // matters; in RUN a stall starts only when a request is present.
    assign frozen = (state == MEM_WAIT) ? !mem_ready : (mem_req && !mem_ready);

    always_comb begin
        pc_en     = 1'b0;
        ifid_en   = 1'b0;
        ifid_clr  = 1'b0;
        idex_en   = 1'b0;
        idex_clr  = 1'b0;
        exmem_en  = 1'b0;
        exmem_clr = 1'b0;
        memwb_en  = 1'b0;
        memwb_clr = 1'b0;
        flush_now = 1'b0;
        state_nxt = state;

        if (!reset) begin
            state_nxt = RUN;
        end else if (frozen) begin
            // Freeze everything up to MEM; WB receives a bubble.
            memwb_en  = 1'b1;
            memwb_clr = 1'b1;
            state_nxt = MEM_WAIT;
        end else begin
            state_nxt = RUN;
            // A taken branch wins over load-use: the dependent instruction
            // is squashed by the flush anyway.
            if (ex_branch_taken) begin
                flush_now = 1'b1;
                pc_en     = 1'b1;
                ifid_en   = 1'b1;
                ifid_clr  = 1'b1;
                idex_en   = 1'b1;
                idex_clr  = 1'b1;
                exmem_en  = 1'b1;
                memwb_en  = 1'b1;
            end else if (load_use) begin
                idex_en   = 1'b1;
                idex_clr  = 1'b1;
                exmem_en  = 1'b1;
                memwb_en  = 1'b1;
            end else begin
                pc_en     = 1'b1;
                ifid_en   = 1'b1;
                idex_en   = 1'b1;
                exmem_en  = 1'b1;
                memwb_en  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (!pc_en)
                stall_count <= sat_inc(stall_count);
            if (flush_now)
                flush_count <= sat_inc(flush_count);
        end
    end

    // Wait counter only advances on MEM_WAIT cycles that are still waiting;
    // it parks at the limit so it never wraps during very long waits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if ((state == MEM_WAIT) && !mem_ready) begin
            if (wait_cnt != WAIT_LIMIT)
                wait_cnt <= wait_cnt + WAIT_ONE;
            if (wait_cnt == WAIT_LIMIT - WAIT_ONE)
                mem_timeout <= 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl (CNT_W=3, MEM_TIMEOUT=8).
module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2;
    logic       ex_mem_read, ex_reg_write, ex_branch_taken;
    logic       mem_req, mem_ready;
    logic       pc_en, ifid_en, ifid_clr, idex_en, idex_clr;
    logic       exmem_en, exmem_clr, memwb_en, memwb_clr;
    logic [2:0] stall_count, flush_count;
    logic       mem_timeout;
    logic [8:0] outs;

    int n_checks = 0;
    int n_fail   = 0;

    // {pc, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, exmem_clr, memwb_en, memwb_clr}
    localparam logic [8:0] O_ALL = 9'b1_10_10_10_10;
    localparam logic [8:0] O_LU  = 9'b0_00_11_10_10;
    localparam logic [8:0] O_BR  = 9'b1_11_11_10_10;
    localparam logic [8:0] O_FRZ = 9'b0_00_00_00_11;
    localparam logic [8:0] O_OFF = 9'b0_00_00_00_00;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W (5),
        .CNT_W      (3),
        .MEM_TIMEOUT(8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .ex_rd          (ex_rd),
        .ex_mem_read    (ex_mem_read),
        .ex_reg_write   (ex_reg_write),
        .ex_branch_taken(ex_branch_taken),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .pc_en          (pc_en),
        .ifid_en        (ifid_en),
        .ifid_clr       (ifid_clr),
        .idex_en        (idex_en),
        .idex_clr       (idex_clr),
        .exmem_en       (exmem_en),
        .exmem_clr      (exmem_clr),
        .memwb_en       (memwb_en),
        .memwb_clr      (memwb_clr),
        .stall_count    (stall_count),
        .flush_count    (flush_count),
        .mem_timeout    (mem_timeout)
    );

    assign outs = {pc_en, ifid_en, ifid_clr, idex_en, idex_clr,
                   exmem_en, exmem_clr, memwb_en, memwb_clr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, mr, rw, br, mreq, mrdy;
        logic [8:0] exp_out;
        int         exp_stall;
        int         exp_flush;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_mem_read = 0; ex_reg_write = 0; ex_branch_taken = 0;
        mem_req = 0; mem_ready = 0;
    endtask

    task automatic apply(input vec_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; ex_rd = v.rd;
        id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
        ex_mem_read = v.mr; ex_reg_write = v.rw; ex_branch_taken = v.br;
        mem_req = v.mreq; mem_ready = v.mrdy;
    endtask

    // Inputs are already driven (just after a rising edge). Check the
    // combinational outputs at the falling edge and the counters after the
    // next rising edge.
    task automatic cycle(input string name, input logic [8:0] eo,
                         input int es, input int ef);
        @(negedge clk);
        check({name, ".outs"}, int'(outs), int'(eo));
        @(posedge clk);
        #1;
        check({name, ".stall"}, int'(stall_count), es);
        check({name, ".flush"}, int'(flush_count), ef);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst.outs", int'(outs), int'(O_OFF));
        @(posedge clk);
        #1;
        check("rst.stall", int'(stall_count), 0);
        check("rst.flush", int'(flush_count), 0);
        check("rst.tmo", int'(mem_timeout), 0);
        reset = 1'b1;
    endtask

    initial begin
        //            rs1 rs2 rd  u1 u2 mr rw br mq my  out    st fl
        tbl[0]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, O_ALL, 0, 0};
        tbl[1]  = '{5'd0, 5'd5, 5'd5, 0, 1, 1, 1, 0, 0, 0, O_LU,  1, 0};
        tbl[2]  = '{5'd0, 5'd0, 5'd0, 0, 1, 1, 1, 0, 0, 0, O_ALL, 1, 0};
        tbl[3]  = '{5'd0, 5'd5, 5'd5, 0, 0, 1, 1, 0, 0, 0, O_ALL, 1, 0};
        tbl[4]  = '{5'd7, 5'd1, 5'd7, 1, 1, 1, 1, 0, 0, 0, O_LU,  2, 0};
        tbl[5]  = '{5'd7, 5'd1, 5'd7, 1, 1, 1, 0, 0, 0, 0, O_ALL, 2, 0};
        tbl[6]  = '{5'd7, 5'd1, 5'd7, 1, 1, 0, 1, 0, 0, 0, O_ALL, 2, 0};
        tbl[7]  = '{5'd0, 5'd5, 5'd5, 0, 1, 1, 1, 1, 0, 0, O_BR,  2, 1};
        tbl[8]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, O_BR,  2, 2};
        tbl[9]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 1, O_ALL, 2, 2};
        tbl[10] = '{5'd9, 5'd3, 5'd9, 0, 1, 1, 1, 0, 0, 0, O_ALL, 2, 2};

        // Reset held for three cycles with random inputs.
        reset = 1'b0;
        idle();
        for (int i = 0; i < 3; i++) begin
            id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); ex_rd = 5'($urandom);
            {id_uses_rs1, id_uses_rs2, ex_mem_read, ex_reg_write,
             ex_branch_taken, mem_req, mem_ready} = 7'($urandom);
            @(negedge clk);
            check("reset.outs", int'(outs), int'(O_OFF));
            check("reset.stall", int'(stall_count), 0);
            check("reset.flush", int'(flush_count), 0);
            check("reset.tmo", int'(mem_timeout), 0);
            @(posedge clk);
        end
        #1;
        idle();
        reset = 1'b1;

        // Single-cycle vectors: load-use, negatives, branch priority.
        for (int i = 0; i < 11; i++) begin
            apply(tbl[i]);
            cycle($sformatf("vec%0d", i), tbl[i].exp_out,
                  tbl[i].exp_stall, tbl[i].exp_flush);
        end

        // Memory wait of four cycles, then release.
        idle();
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 1; i <= 4; i++)
            cycle($sformatf("wait%0d", i), O_FRZ, i, 0);
        mem_ready = 1;
        cycle("wait.release", O_ALL, 4, 0);
        mem_req = 0; mem_ready = 0;
        cycle("wait.run", O_ALL, 4, 0);

        // Branch arriving during a wait is acted on in the release cycle only.
        mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
        cycle("wbr1", O_FRZ, 5, 0);
        cycle("wbr2", O_FRZ, 6, 0);
        mem_ready = 1;
        cycle("wbr.release", O_BR, 6, 1);
        idle();

        // Reset asserted mid-wait returns to RUN.
        mem_req = 1; mem_ready = 0;
        cycle("mid1", O_FRZ, 7, 1);
        cycle("mid2", O_FRZ, 7, 1);
        do_reset();
        mem_req = 0; mem_ready = 0;
        cycle("mid.run", O_ALL, 0, 0);

        // Timeout after 8 MEM_WAIT cycles; stall_count saturates at 7.
        mem_req = 1; mem_ready = 0;
        for (int k = 1; k <= 10; k++) begin
            cycle($sformatf("tmo%0d", k), O_FRZ, (k < 7) ? k : 7, 0);
            check($sformatf("tmo%0d.flag", k), int'(mem_timeout), (k >= 9) ? 1 : 0);
        end
        mem_ready = 1;
        cycle("tmo.release", O_ALL, 7, 0);
        check("tmo.sticky1", int'(mem_timeout), 1);
        idle();
        cycle("tmo.idle", O_ALL, 7, 0);
        check("tmo.sticky2", int'(mem_timeout), 1);
        do_reset();

        // flush_count saturation.
        ex_branch_taken = 1;
        for (int k = 1; k <= 9; k++)
            cycle($sformatf("fsat%0d", k), O_BR, 0, (k < 7) ? k : 7);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage RISC-V pipeline.
- Drives the enable/clear pair of every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable.
- Handles load-use hazards, taken-branch flushes and multi-cycle data-memory waits, plus saturating performance counters and a memory-timeout flag.
- Sits directly upstream of the pipeline registers. Every enable/clear input of those registers comes from this block.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- CNT_W, 16, width of the stall and flush counters.
- MEM_TIMEOUT, 64, number of consecutive MEM_WAIT cycles after which mem_timeout sets.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- id_rs1  input  REG_ADDR_W  source register 1 of the instruction in ID.
- id_rs2  input  REG_ADDR_W  source register 2 of the instruction in ID.
- id_uses_rs1  input  1  ID instruction reads rs1.
- id_uses_rs2  input  1  ID instruction reads rs2.
- ex_rd  input  REG_ADDR_W  destination register of the instruction in EX.
- ex_mem_read  input  1  EX instruction is a load.
- ex_reg_write  input  1  EX instruction writes the register file.
- ex_branch_taken  input  1  branch/jump resolved taken in EX.
- mem_req  input  1  MEM stage has an active load/store.
- mem_ready  input  1  data memory completes the access this cycle.
- pc_en  output  1  PC update enable.
- ifid_en, ifid_clr  output  1 each  IF/ID register enable/clear.
- idex_en, idex_clr  output  1 each  ID/EX register enable/clear.
- exmem_en, exmem_clr  output  1 each  EX/MEM register enable/clear.
- memwb_en, memwb_clr  output  1 each  MEM/WB register enable/clear.
- stall_count  output  CNT_W  cycles with pc_en=0, saturating.
- flush_count  output  CNT_W  branch-flush cycles, saturating.
- mem_timeout  output  1  sticky memory-timeout flag.

Behaviour:
- **Register contract:** the pipeline registers honour clear only when enable=1. Every clr=1 is therefore issued together with the matching en=1. clr=1 with en=0 is illegal.
- **Outputs:** all enables/clears are combinational from state and inputs, so they take effect on the same edge. While reset=0, all en=0 and all clr=0.
- **FSM states:** RUN, MEM_WAIT.
  - Reset state is RUN.
  - Reset also clears both counters, the wait counter and mem_timeout.
- **RUN, priority order for the current cycle:**
  1. Memory stall (mem_req=1 and mem_ready=0):
     - pc_en=ifid_en=idex_en=exmem_en=0.
     - memwb_en=1 with memwb_clr=1, inserting a bubble into WB.
     - Next state is MEM_WAIT.
  2. Branch flush (ex_branch_taken=1):
     - pc_en=1.
     - ifid_en=1 with ifid_clr=1; idex_en=1 with idex_clr=1.
     - exmem_en=memwb_en=1 with no clear.
  3. Load-use stall:
     - Condition: ex_mem_read=1, ex_reg_write=1, ex_rd≠0, and at least one of (id_uses_rs1 and id_rs1=ex_rd) or (id_uses_rs2 and id_rs2=ex_rd).
     - pc_en=ifid_en=0.
     - idex_en=1 with idex_clr=1.
     - exmem_en=memwb_en=1.
  4. Otherwise all en=1 and all clr=0.
- **Branch beats load-use:** when both conditions hold, the branch wins, because the dependent instruction is flushed anyway.
- **MEM_WAIT:**
  - While mem_ready=0, outputs are identical to RUN rule 1.
  - The cycle mem_ready=1: outputs follow RUN rules 2–4, evaluated on current inputs, and next state is RUN.
  - A branch or load-use condition present during the wait is held by the frozen stages and is acted on in the release cycle. No extra latching.
- **Wait counter (internal):**
  - Increments each cycle in MEM_WAIT with mem_ready=0.
  - Cleared on exit from MEM_WAIT.
  - When it reaches MEM_TIMEOUT, mem_timeout sets to 1 and holds until reset. The pipeline keeps waiting.
- **stall_count:** +1 on every rising edge where pc_en=0 and reset=1. Saturates at 2^CNT_W−1.
- **flush_count:** +1 on every edge where rule 2 applied. Saturates the same way.
- **Reset mid-operation:** reset asserted in MEM_WAIT returns to RUN immediately; outputs are forced inactive while reset=0.

Test Plan:
- **Reset:** assert reset=0 for 3 cycles with random inputs -> all en/clr=0, stall_count=0, flush_count=0, mem_timeout=0. After release with idle inputs -> all en=1, all clr=0.
- **Load-use:**
  - Hazard case: ex_mem_read=1, ex_reg_write=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 for one cycle -> pc_en=0, ifid_en=0, idex_en=1, idex_clr=1, stall_count=1.
  - Negative cases: repeating with ex_rd=0, or with id_uses_rs2=0 -> no stall.
- **Branch flush:** ex_branch_taken=1 together with a load-use condition -> ifid_clr=idex_clr=1 with both en=1, pc_en=1, flush_count=1, stall_count unchanged.
- **Memory wait:** mem_req=1, mem_ready=0 for 4 cycles, then mem_ready=1 -> 4 freeze cycles with memwb_en=memwb_clr=1, stall_count=4, then all en=1, FSM back to RUN.
- **Timeout:** MEM_TIMEOUT=8, hold mem_ready=0 for 10 cycles -> mem_timeout rises after the 8th wait cycle and stays 1 after mem_ready=1, until reset.
- **Saturation:** CNT_W=3, 10 consecutive stall cycles -> stall_count=7 and holds.
